// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage rounding pipeline for a small floating-point format.
// Stage 1 captures the operand and its round-up decision. Stage 2 applies the
// increment, renormalising or saturating when needed. Valid/ready handshakes
// allow one result per cycle while the consumer accepts.
module fp_round_pipe #(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exponent,
  input  logic [SIG_W-1:0] significand,
  input  logic             round_bit,
  input  logic             sticky_bit,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F,
  output logic             ovf,
  output logic             inexact,
  output logic [CNT_W-1:0] sat_count
);

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [SIG_W-1:0] SIG_ONES = {SIG_W{1'b1}};
  localparam logic [SIG_W-1:0] SIG_NORM = {1'b1, {(SIG_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [SIG_W-1:0] s1_sig_q, s1_sig_d;
  logic             s1_up_q, s1_up_d;
  logic             s1_inexact_q, s1_inexact_d;

  // Stage 2 registers
  logic             s2_valid_q, s2_valid_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [SIG_W-1:0] f_q, f_d;
  logic             ovf_q, ovf_d;
  logic             inexact_q, inexact_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;

  logic             round_up_in;
  logic             s2_free;
  logic             s2_load;
  logic             in_hs;
  logic             out_hs;
  logic [EXP_W-1:0] rnd_exp;
  logic [SIG_W-1:0] rnd_sig;
  logic             rnd_ovf;

  // Handshake and stage-advance conditions; in_ready is forced low during reset
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s2_load  = s1_valid_q && s2_free;
    in_ready = rst_n && (!s1_valid_q || s2_free);
    in_hs    = in_valid && in_ready;
    out_hs   = s2_valid_q && out_ready;
  end

  // Round-up decision for the incoming operand, selected by rounding mode
  always_comb begin
    round_up_in = 1'b0;
    case (mode)
      2'b01:   round_up_in = round_bit;
      2'b10:   round_up_in = round_bit && (sticky_bit || significand[0]);
      default: round_up_in = 1'b0;
    endcase
  end

  // Stage 1 next state: load a new operand, or empty once stage 2 takes it
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_exp_d     = s1_exp_q;
    s1_sig_d     = s1_sig_q;
    s1_up_d      = s1_up_q;
    s1_inexact_d = s1_inexact_q;
    if (in_hs) begin
      s1_valid_d   = 1'b1;
      s1_exp_d     = exponent;
      s1_sig_d     = significand;
      s1_up_d      = round_up_in;
      s1_inexact_d = round_bit || sticky_bit;
    end else if (s2_load) begin
      s1_valid_d   = 1'b0;
    end
  end

  // Apply the increment with renormalisation on carry-out and saturation at max exponent
  always_comb begin
    rnd_exp = s1_exp_q;
    rnd_sig = s1_sig_q;
    rnd_ovf = 1'b0;
    if (s1_up_q) begin
      if (s1_sig_q != SIG_ONES) begin
        rnd_sig = s1_sig_q + {{(SIG_W-1){1'b0}}, 1'b1};
      end else if (s1_exp_q != EXP_ONES) begin
        rnd_exp = s1_exp_q + {{(EXP_W-1){1'b0}}, 1'b1};
        rnd_sig = SIG_NORM;
      end else begin
        rnd_exp = EXP_ONES;
        rnd_sig = SIG_ONES;
        rnd_ovf = 1'b1;
      end
    end
  end

  // Stage 2 next state: take the rounded result, hold while stalled, empty after delivery
  always_comb begin
    s2_valid_d  = s2_valid_q;
    e_d         = e_q;
    f_d         = f_q;
    ovf_d       = ovf_q;
    inexact_d   = inexact_q;
    sat_count_d = sat_count_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      e_d        = rnd_exp;
      f_d        = rnd_sig;
      ovf_d      = rnd_ovf;
      inexact_d  = s1_inexact_q;
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end
    if (out_hs && ovf_q && (sat_count_q != CNT_ONES)) begin
      sat_count_d = sat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_exp_q     <= '0;
      s1_sig_q     <= '0;
      s1_up_q      <= 1'b0;
      s1_inexact_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      e_q          <= '0;
      f_q          <= '0;
      ovf_q        <= 1'b0;
      inexact_q    <= 1'b0;
      sat_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_exp_q     <= s1_exp_d;
      s1_sig_q     <= s1_sig_d;
      s1_up_q      <= s1_up_d;
      s1_inexact_q <= s1_inexact_d;
      s2_valid_q   <= s2_valid_d;
      e_q          <= e_d;
      f_q          <= f_d;
      ovf_q        <= ovf_d;
      inexact_q    <= inexact_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign E         = e_q;
  assign F         = f_q;
  assign ovf       = ovf_q;
  assign inexact   = inexact_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Testbench for fp_round_pipe: directed vectors, saturation runs, random
// backpressure and a mid-stream reset, all checked against a queue-based model.
module tb_fp_round_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready, in_ready2;
  logic [2:0] exponent;
  logic [3:0] significand;
  logic       round_bit;
  logic       sticky_bit;
  logic [1:0] mode;
  logic       out_valid, out_valid2;
  logic       out_ready;
  logic [2:0] E, E2;
  logic [3:0] F, F2;
  logic       ovf, ovf2;
  logic       inexact, inexact2;
  logic [7:0] sat_count;
  logic [1:0] sat_count_w2;

  typedef struct {
    int e; int s; bit r; bit st; int md;
    bit lit; int le; int lf; bit lovf; bit linx;
  } vec_t;

  typedef struct {
    int e; int f; bit ovf; bit inx; int cyc;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   sat8 = 0;
  int   sat2 = 0;
  res_t q[$];
  bit   stall_prev = 0;
  int   prev_e, prev_f;
  bit   prev_ovf, prev_inx;
  vec_t tbl[12];

  fp_round_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exponent(exponent), .significand(significand), .round_bit(round_bit),
    .sticky_bit(sticky_bit), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .E(E), .F(F), .ovf(ovf), .inexact(inexact),
    .sat_count(sat_count)
  );

  fp_round_pipe #(.EXP_W(3), .SIG_W(4), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .exponent(exponent), .significand(significand), .round_bit(round_bit),
    .sticky_bit(sticky_bit), .mode(mode), .out_valid(out_valid2),
    .out_ready(out_ready), .E(E2), .F(F2), .ovf(ovf2), .inexact(inexact2),
    .sat_count(sat_count_w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rounding: add the round-up to the significand as an integer
  function automatic res_t model(int e, int s, bit r, bit st, int md);
    res_t res;
    int up;
    int sum;
    if (md == 1) up = r;
    else if (md == 2) up = (r && (st || (s % 2 == 1))) ? 1 : 0;
    else up = 0;
    sum = s + up;
    res.inx = r || st;
    res.cyc = 0;
    if (sum < 16) begin
      res.e = e; res.f = sum; res.ovf = 0;
    end else if (e < 7) begin
      res.e = e + 1; res.f = 8; res.ovf = 0;
    end else begin
      res.e = 7; res.f = 15; res.ovf = 1;
    end
    return res;
  endfunction

  function automatic vec_t mk(int e, int s, bit r, bit st, int md,
                              bit lit, int le, int lf, bit lovf, bit linx);
    vec_t v;
    v.e = e; v.s = s; v.r = r; v.st = st; v.md = md;
    v.lit = lit; v.le = le; v.lf = lf; v.lovf = lovf; v.linx = linx;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one operand and hold it until the handshake edge
  task automatic applyStimulus(input vec_t v);
    res_t m;
    bit   got;
    if (v.lit) begin
      m = model(v.e, v.s, v.r, v.st, v.md);
      checkOutput("model_E", m.e, v.le);
      checkOutput("model_F", m.f, v.lf);
      checkOutput("model_ovf", int'(m.ovf), int'(v.lovf));
      checkOutput("model_inexact", int'(m.inx), int'(v.linx));
    end
    exponent    = v.e[2:0];
    significand = v.s[3:0];
    round_bit   = v.r;
    sticky_bit  = v.st;
    mode        = v.md[1:0];
    in_valid    = 1'b1;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    #1;
    checkOutput("drain", q.size(), 0);
  endtask

  // Consumer readiness pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: checks every cycle against the queue model
  always @(negedge clk) begin
    bit   exp_valid;
    res_t m;
    cyc++;
    exp_valid = (q.size() > 0) && (cyc - q[0].cyc >= 2);
    checkOutput("sat_count", int'(sat_count), sat8);
    checkOutput("sat_count_w2", int'(sat_count_w2), sat2);
    checkOutput("in_ready", int'(in_ready), int'(rst_n && (q.size() < 2 || out_ready)));
    checkOutput("in_ready_w2", int'(in_ready2), int'(in_ready));
    checkOutput("out_valid", int'(out_valid), int'(exp_valid));
    checkOutput("out_valid_w2", int'(out_valid2), int'(exp_valid));
    if (stall_prev) begin
      checkOutput("hold_E", int'(E), prev_e);
      checkOutput("hold_F", int'(F), prev_f);
      checkOutput("hold_ovf", int'(ovf), int'(prev_ovf));
      checkOutput("hold_inexact", int'(inexact), int'(prev_inx));
    end
    if (exp_valid) begin
      checkOutput("E", int'(E), q[0].e);
      checkOutput("F", int'(F), q[0].f);
      checkOutput("ovf", int'(ovf), int'(q[0].ovf));
      checkOutput("inexact", int'(inexact), int'(q[0].inx));
      checkOutput("E_w2", int'(E2), q[0].e);
      checkOutput("F_w2", int'(F2), q[0].f);
      checkOutput("ovf_w2", int'(ovf2), int'(q[0].ovf));
      checkOutput("inexact_w2", int'(inexact2), int'(q[0].inx));
      if (rst_n && out_ready) begin
        if (q[0].ovf) begin
          if (sat8 < 255) sat8++;
          if (sat2 < 3) sat2++;
        end
        void'(q.pop_front());
      end
    end
    if (rst_n && in_valid && in_ready) begin
      m = model(int'(exponent), int'(significand), round_bit, sticky_bit, int'(mode));
      m.cyc = cyc;
      q.push_back(m);
    end
    if (!rst_n) begin
      q.delete();
      sat8 = 0;
      sat2 = 0;
    end
    stall_prev = rst_n && out_valid && !out_ready;
    prev_e   = int'(E);
    prev_f   = int'(F);
    prev_ovf = ovf;
    prev_inx = inexact;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    tbl[0]  = mk(2, 7,  1, 0, 1, 1, 2, 8,  0, 1);
    tbl[1]  = mk(2, 15, 1, 0, 1, 1, 3, 8,  0, 1);
    tbl[2]  = mk(1, 15, 0, 0, 1, 1, 1, 15, 0, 0);
    tbl[3]  = mk(7, 15, 1, 0, 1, 1, 7, 15, 1, 1);
    tbl[4]  = mk(2, 4,  1, 0, 2, 1, 2, 4,  0, 1);
    tbl[5]  = mk(2, 5,  1, 0, 2, 1, 2, 6,  0, 1);
    tbl[6]  = mk(2, 4,  1, 1, 2, 1, 2, 5,  0, 1);
    tbl[7]  = mk(2, 6,  1, 0, 0, 1, 2, 6,  0, 1);
    tbl[8]  = mk(3, 10, 1, 1, 3, 1, 3, 10, 0, 1);
    tbl[9]  = mk(0, 0,  0, 1, 2, 1, 0, 0,  0, 1);
    tbl[10] = mk(6, 15, 1, 0, 2, 1, 7, 8,  0, 1);
    tbl[11] = mk(7, 15, 1, 1, 2, 1, 7, 15, 1, 1);

    rst_n = 1'b0; in_valid = 1'b0; exponent = '0; significand = '0;
    round_bit = 1'b0; sticky_bit = 1'b0; mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back directed vectors at full throughput
    ready_mode = 0;
    foreach (tbl[i]) applyStimulus(tbl[i]);
    in_valid = 1'b0;
    waitDrain();

    // Saturation runs: counter of width 2 must stick at 3
    for (int i = 0; i < 5; i++) applyStimulus(tbl[3]);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("sat_count_literal", int'(sat_count), 7);
    checkOutput("sat_count_w2_literal", int'(sat_count_w2), 3);

    // Random backpressure with random operands, then the table again
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      v = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
      applyStimulus(v);
    end
    foreach (tbl[i]) applyStimulus(tbl[i]);
    in_valid = 1'b0;
    ready_mode = 0;
    waitDrain();

    // Reset with two operands in flight; neither may appear afterwards
    ready_mode = 2;
    @(posedge clk);
    #1;
    applyStimulus(tbl[3]);
    applyStimulus(tbl[0]);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    checkOutput("out_valid_after_reset", int'(out_valid), 0);
    checkOutput("sat_count_after_reset", int'(sat_count), 0);
    repeat (10) @(posedge clk);
    #1;

    // Traffic still flows after the reset
    applyStimulus(tbl[1]);
    in_valid = 1'b0;
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
